// File: rtl/ray_queue_pkg.sv
// +-------------------------------------------------------------------+
// | ray_queue_pkg : shared widths, entry type and frame-state codes   |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

package ray_queue_pkg;

  localparam int RAY_COORD_W = 11;
  localparam int RAY_VEC_W   = 96;
  localparam int RAY_ENTRY_W = 2 * RAY_COORD_W + 2 * RAY_VEC_W;

  // Packed {x, y, origin, direction}, x in the MSBs.
  typedef logic [RAY_ENTRY_W-1:0] ray_entry_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } frame_state_t;

  function automatic ray_entry_t ray_pack(
    input logic [RAY_COORD_W-1:0] x,
    input logic [RAY_COORD_W-1:0] y,
    input logic [RAY_VEC_W-1:0]   origin,
    input logic [RAY_VEC_W-1:0]   direction
  );
    return {x, y, origin, direction};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ray_queue_if.sv
// +-------------------------------------------------------------------+
// | ray_queue_if : queue-to-core ray handshake (valid/ready)          |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

interface ray_queue_if;
  import ray_queue_pkg::*;

  logic [RAY_COORD_W-1:0] ray_x;
  logic [RAY_COORD_W-1:0] ray_y;
  logic [RAY_VEC_W-1:0]   ray_origin;
  logic [RAY_VEC_W-1:0]   ray_direction;
  logic                   ray_valid;
  logic                   ray_ready;

  modport master (
    output ray_x, ray_y, ray_origin, ray_direction, ray_valid,
    input  ray_ready
  );

  modport slave (
    input  ray_x, ray_y, ray_origin, ray_direction, ray_valid,
    output ray_ready
  );

endinterface

`default_nettype wire

// File: rtl/ray_fifo_mem.sv
// +-------------------------------------------------------------------+
// | ray_fifo_mem : DEPTH x entry storage, sync write, async head read |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module ray_fifo_mem
  import ray_queue_pkg::*;
#(
  parameter  int DEPTH    = 16,
  localparam int c_addr_w = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [c_addr_w-1:0] wr_addr,
  input  ray_entry_t          wr_data,
  input  logic [c_addr_w-1:0] rd_addr,
  output ray_entry_t          rd_data
);

  ray_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/ray_queue.sv
// +-------------------------------------------------------------------+
// | ray_queue : caster-side ray FIFO with ce throttle and frame FSM   |
// | Optional RAY_QUEUE_STATS_EN adds stall_cycles / max_occupancy.    |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module ray_queue
  import ray_queue_pkg::*;
#(
  parameter  int DEPTH    = 16,
  parameter  int AFULL    = 14,
  parameter  int RES_X    = 640,
  parameter  int RES_Y    = 480,
  localparam int c_addr_w = $clog2(DEPTH),
  localparam int c_occ_w  = c_addr_w + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [RAY_COORD_W-1:0] in_image_x,
  input  logic [RAY_COORD_W-1:0] in_image_y,
  input  logic [RAY_VEC_W-1:0]   in_ray_origin,
  input  logic [RAY_VEC_W-1:0]   in_ray_direction,
  input  logic                   in_valid,
  output logic                   caster_ce,
  ray_queue_if.master            core,
  output logic [c_occ_w-1:0]     occupancy,
  output logic                   frame_done,
  output logic                   overflow
`ifdef RAY_QUEUE_STATS_EN
  ,
  output logic [31:0]            stall_cycles,
  output logic [c_occ_w-1:0]     max_occupancy
`endif
);

  localparam logic [c_occ_w-1:0]     c_full   = c_occ_w'(DEPTH);
  localparam logic [c_occ_w-1:0]     c_afull  = c_occ_w'(AFULL);
  localparam logic [RAY_COORD_W-1:0] c_last_x = RAY_COORD_W'(RES_X - 1);
  localparam logic [RAY_COORD_W-1:0] c_last_y = RAY_COORD_W'(RES_Y - 1);

  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_occ_w-1:0]  r_occ;
  logic                r_ce;
  logic                r_ce_d;
  logic                r_ovf;
  frame_state_t        r_state;
  frame_state_t        w_state_next;

  logic                w_pop;
  logic                w_push_req;
  logic                w_push;
  logic                w_drop;
  logic                w_full;
  logic                w_in_first;
  logic                w_head_last;
  logic                w_frame_done;
  logic [c_occ_w-1:0]  w_occ_next;
  ray_entry_t          w_head;

  assign w_full      = (r_occ == c_full);
  assign w_pop       = (r_occ != '0) && core.ray_ready;
  // ce_d marks a freshly latched caster beat; held repeats arrive with ce_d low.
  assign w_push_req  = in_valid && r_ce_d;
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_drop      = w_push_req && w_full && !w_pop;
  assign w_in_first  = (in_image_x == '0) && (in_image_y == '0);
  assign w_head_last = (w_head[RAY_ENTRY_W-1 -: RAY_COORD_W] == c_last_x) &&
                       (w_head[RAY_ENTRY_W-RAY_COORD_W-1 -: RAY_COORD_W] == c_last_y);

  always_comb begin
    w_occ_next = r_occ;
    case ({w_push, w_pop})
      2'b10:   w_occ_next = r_occ + c_occ_w'(1);
      2'b01:   w_occ_next = r_occ - c_occ_w'(1);
      default: w_occ_next = r_occ;
    endcase
  end

  ray_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_push),
    .wr_addr (r_wr_ptr),
    .wr_data (ray_pack(in_image_x, in_image_y, in_ray_origin, in_ray_direction)),
    .rd_addr (r_rd_ptr),
    .rd_data (w_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_ce     <= 1'b0;
      r_ce_d   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_occ  <= w_occ_next;
      r_ce   <= (w_occ_next < c_afull);
      r_ce_d <= r_ce;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A new frame's first pixel arriving together with the old frame's last pop keeps RUN.
  always_comb begin
    w_state_next = r_state;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_push && w_in_first) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_pop && w_head_last) begin
          w_frame_done = 1'b1;
          w_state_next = (w_push && w_in_first) ? ST_RUN : ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

`ifdef RAY_QUEUE_STATS_EN
  logic               w_frame_start;
  logic [31:0]        r_stall;
  logic [c_occ_w-1:0] r_max_occ;

  assign w_frame_start = (r_state == ST_IDLE) && (w_state_next == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall   <= '0;
      r_max_occ <= '0;
    end else if (w_frame_start) begin
      r_stall   <= '0;
      r_max_occ <= '0;
    end else begin
      if ((r_state == ST_RUN) && !r_ce) begin
        r_stall <= r_stall + 32'd1;
      end
      if (r_occ > r_max_occ) begin
        r_max_occ <= r_occ;
      end
    end
  end

  assign stall_cycles  = r_stall;
  assign max_occupancy = r_max_occ;
`endif

  assign caster_ce          = r_ce;
  assign occupancy          = r_occ;
  assign overflow           = r_ovf;
  assign frame_done         = w_frame_done;
  assign core.ray_valid     = (r_occ != '0);
  assign core.ray_x         = w_head[RAY_ENTRY_W-1 -: RAY_COORD_W];
  assign core.ray_y         = w_head[RAY_ENTRY_W-RAY_COORD_W-1 -: RAY_COORD_W];
  assign core.ray_origin    = w_head[2*RAY_VEC_W-1 -: RAY_VEC_W];
  assign core.ray_direction = w_head[RAY_VEC_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_ray_queue.sv
// +-------------------------------------------------------------------+
// | tb_ray_queue : directed self-checking bench for ray_queue         |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module tb_ray_queue;
  import ray_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int AFULL = 14;
  localparam int RES_X = 4;
  localparam int RES_Y = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] in_image_x;
  logic [10:0] in_image_y;
  logic [95:0] in_ray_origin;
  logic [95:0] in_ray_direction;
  logic        in_valid;
  logic        caster_ce;
  logic [4:0]  occupancy;
  logic        frame_done;
  logic        overflow;
`ifdef RAY_QUEUE_STATS_EN
  logic [31:0] stall_cycles;
  logic [4:0]  max_occupancy;
`endif

  ray_queue_if core_if ();

  ray_queue #(
    .DEPTH (DEPTH),
    .AFULL (AFULL),
    .RES_X (RES_X),
    .RES_Y (RES_Y)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_image_x       (in_image_x),
    .in_image_y       (in_image_y),
    .in_ray_origin    (in_ray_origin),
    .in_ray_direction (in_ray_direction),
    .in_valid         (in_valid),
    .caster_ce        (caster_ce),
    .core             (core_if),
    .occupancy        (occupancy),
    .frame_done       (frame_done),
    .overflow         (overflow)
`ifdef RAY_QUEUE_STATS_EN
    ,
    .stall_cycles     (stall_cycles),
    .max_occupancy    (max_occupancy)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: expected queue contents and flags
  ray_entry_t q[$];
  bit exp_run, exp_ovf, exp_ce, fresh;
  bit streaming, frame_mode, force_mode;
  int next_id, limit, pix;
  int fd_count, obs_pops, obs_max;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_next();
    if (frame_mode) begin
      if (pix >= RES_X * RES_Y) begin
        in_valid = 1'b0;
        return;
      end
      in_image_x = 11'(pix % RES_X);
      in_image_y = 11'(pix / RES_X);
      pix++;
    end else begin
      if (next_id >= limit) begin
        in_valid = 1'b0;
        return;
      end
      in_image_x = 11'(16 + next_id);
      in_image_y = 11'(next_id);
    end
    in_ray_origin    = {32'(next_id), 32'hA5A5_0000 ^ 32'(next_id), ~32'(next_id)};
    in_ray_direction = {32'h1234_0000 + 32'(next_id), 32'(next_id * 7), 32'hFFFF_0000 | 32'(next_id)};
    in_valid = 1'b1;
    next_id++;
  endtask

  // One clock: check outputs against model, advance model, clock, update caster latch.
  task automatic step();
    ray_entry_t e;
    ray_entry_t head;
    bit pop, push, exp_fd, upd;
    #1;
    exp_fd = 1'b0;
    head = {core_if.ray_x, core_if.ray_y, core_if.ray_origin, core_if.ray_direction};
    if (q.size() > 0) begin
      e = q[0];
      exp_fd = exp_run && (core_if.ray_ready === 1'b1) &&
               (e[213:203] == 11'(RES_X - 1)) && (e[202:192] == 11'(RES_Y - 1));
    end
    chk("occupancy", occupancy, q.size());
    chk("caster_ce", caster_ce, exp_ce);
    chk("ray_valid", core_if.ray_valid, q.size() > 0);
    if (q.size() > 0) chk("head_entry", head, e);
    chk("overflow", overflow, exp_ovf);
    chk("frame_done", frame_done, exp_fd);
    if (frame_done === 1'b1) fd_count++;
    if (core_if.ray_valid === 1'b1 && core_if.ray_ready === 1'b1) obs_pops++;
    if (int'(occupancy) > obs_max) obs_max = int'(occupancy);

    pop  = (q.size() > 0) && (core_if.ray_ready === 1'b1);
    push = in_valid && fresh;
    if (pop) begin
      if (exp_fd) exp_run = 1'b0;
      e = q.pop_front();
    end
    if (push) begin
      if (q.size() >= DEPTH) begin
        exp_ovf = 1'b1;
      end else begin
        q.push_back({in_image_x, in_image_y, in_ray_origin, in_ray_direction});
        if (in_image_x == 11'd0 && in_image_y == 11'd0) exp_run = 1'b1;
      end
    end
    exp_ce = (q.size() < AFULL);
    upd = caster_ce;
    @(posedge clk);
    #1;
    if (force_mode) load_next();
    else if (upd) begin
      if (streaming) load_next();
      else in_valid = 1'b0;
    end
    fresh = upd || force_mode;
  endtask

  initial begin
    in_image_x = '0; in_image_y = '0; in_ray_origin = '0; in_ray_direction = '0;
    in_valid = 1'b0;
    core_if.ray_ready = 1'b0;
    exp_run = 0; exp_ovf = 0; exp_ce = 0; fresh = 0;
    streaming = 0; frame_mode = 0; force_mode = 0;
    next_id = 0; limit = 10; pix = 0; fd_count = 0; obs_pops = 0; obs_max = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_caster_ce", caster_ce, 1'b0);
    chk("rst_ray_valid", core_if.ray_valid, 1'b0);
    chk("rst_occupancy", occupancy, 5'd0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;

    // 10 rays, core always ready
    core_if.ray_ready = 1'b1;
    streaming = 1;
    step();
    chk("ce_first_edge", caster_ce, 1'b1);
    repeat (14) step();
    chk("t1_pops", obs_pops, 10);
    chk("t1_max_occ_le1", obs_max <= 1, 1'b1);
    chk("t1_empty", occupancy, 5'd0);

    // Core stalled: throttle engages
    limit = 100000;
    core_if.ray_ready = 1'b0;
    obs_max = 0;
    repeat (25) step();
    chk("t2_occ", occupancy, 5'd15);
    chk("t2_max_occ", obs_max, 15);
    chk("t2_ce_low", caster_ce, 1'b0);
    chk("t2_ovf", overflow, 1'b0);

    // Resume: steady state settles three below the stall level
    core_if.ray_ready = 1'b1;
    repeat (30) step();
    chk("t3_ce_high", caster_ce, 1'b1);
    chk("t3_occ", occupancy, 5'd12);

    // Fill to full by forcing ce_d
    core_if.ray_ready = 1'b0;
    repeat (25) step();
    force dut.r_ce_d = 1'b1;
    load_next();
    fresh = 1'b1;
    force_mode = 1'b1;
    step();
    chk("t4_full", occupancy, 5'd16);
    chk("t4_full_ovf", overflow, 1'b0);
    core_if.ray_ready = 1'b1;
    step();
    chk("t4_pushpop_occ", occupancy, 5'd16);
    chk("t4_pushpop_ovf", overflow, 1'b0);
    core_if.ray_ready = 1'b0;
    step();
    chk("t4_drop_ovf", overflow, 1'b1);
    chk("t4_drop_occ", occupancy, 5'd16);
    force_mode = 1'b0;
    in_valid = 1'b0;
    fresh = 1'b0;
    release dut.r_ce_d;
    repeat (3) step();
    chk("t4_ovf_sticky", overflow, 1'b1);
    core_if.ray_ready = 1'b1;
    repeat (25) step();
    streaming = 0;
    repeat (20) step();
    chk("t4_drained", occupancy, 5'd0);
    chk("t4_ovf_sticky2", overflow, 1'b1);

    // Reduced-resolution frame
    chk("t5_idle_before", dut.r_state, ST_IDLE);
    frame_mode = 1; pix = 0; streaming = 1; fd_count = 0;
    repeat (14) step();
    chk("t5_fd_count", fd_count, 1);
    chk("t5_idle_after", dut.r_state, ST_IDLE);
    chk("t5_empty", occupancy, 5'd0);

    // Reset mid-frame with 7 queued
    pix = 0;
    core_if.ray_ready = 1'b0;
    for (int i = 0; i < 20 && q.size() < 7; i++) step();
    chk("t6_queued", occupancy, 5'd7);
    chk("t6_run", dut.r_state, ST_RUN);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", core_if.ray_valid, 1'b0);
    chk("t6_async_occ", occupancy, 5'd0);
    chk("t6_async_ce", caster_ce, 1'b0);
    chk("t6_async_ovf", overflow, 1'b0);
    q.delete();
    exp_run = 0; exp_ovf = 0; exp_ce = 0; fresh = 0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pix = 0; fd_count = 0;
    core_if.ray_ready = 1'b1;
    repeat (16) step();
    chk("t6_fd_count", fd_count, 1);
    chk("t6_idle_after", dut.r_state, ST_IDLE);
    chk("t6_empty", occupancy, 5'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
